// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
// Shares one UDP transmit path between NUM_REQ packet sources. Each packet runs
// IDLE -> GRANT -> SEND -> DRAIN -> GAP; illegal lengths are rejected with a
// drop pulse and still pay the inter-packet gap.
//
// Build option: define UDP_ARB_PRIO0_EN to give source 0 strict priority
// (source-0 wins leave the round-robin pointer untouched). Undefined: pure
// round-robin across all sources.
//
// Ports
//   clock, reset_n  : clock (rising edge) and asynchronous active-low reset
//   req             : per-source packet pending (level)
//   req_length      : payload length, source i at [16i+15:16i]
//   req_port_id     : local port offset ID, source i at [8i+7:8i]
//   req_dst_port    : destination UDP port, source i at [16i+15:16i]
//   req_data        : first-word-fall-through payload byte, source i at [8i+7:8i]
//   grant           : one-hot granted source, GRANT through DRAIN
//   rd_en           : byte consumed this cycle (SEND only)
//   drop            : one-cycle pulse for a rejected request
//   udp_tx_enable   : one pulse per payload byte, contiguous
//   udp_data        : payload byte (combinational mux, 0 outside SEND)
//   udp_length      : payload length of the last accepted packet
//   udp_port_id     : port offset ID of the last accepted packet
//   udp_dst_port    : destination port of the last accepted packet
//   udp_active      : sender still shifting header/payload
//   busy            : arbiter not idle
module udp_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [15:0] MAX_LEN    = 16'd1444,
  parameter int unsigned GAP_CYCLES = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_length,
  input  logic [8*NUM_REQ-1:0]   req_port_id,
  input  logic [16*NUM_REQ-1:0]  req_dst_port,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     rd_en,
  output logic [NUM_REQ-1:0]     drop,
  output logic                   udp_tx_enable,
  output logic [7:0]             udp_data,
  output logic [15:0]            udp_length,
  output logic [7:0]             udp_port_id,
  output logic [15:0]            udp_dst_port,
  input  logic                   udp_active,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_ok;
  logic [15:0]        byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_any;
  logic               pick_ok;
  logic [15:0]        pick_len;
  logic [NUM_REQ-1:0] pick_onehot;

  logic [15:0] len_arr  [NUM_REQ];
  logic [7:0]  pid_arr  [NUM_REQ];
  logic [15:0] dst_arr  [NUM_REQ];
  logic [7:0]  data_arr [NUM_REQ];

  // Unpack the flat per-source buses into indexable arrays
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_arr[g]  = req_length[16*g +: 16];
    assign pid_arr[g]  = req_port_id[8*g +: 8];
    assign dst_arr[g]  = req_dst_port[16*g +: 16];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // Round-robin winner: search upward from last_grant+1 with wrap. The loop
  // runs from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    pick_any = |req;
    pick_idx = '0;
    cand     = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = IDX_W'((32'(last_grant) + 32'(k)) % NUM_REQ);
      if (req[cand]) pick_idx = cand;
    end
`ifdef UDP_ARB_PRIO0_EN
    if (req[0]) pick_idx = '0;
`endif
    pick_len    = len_arr[pick_idx];
    pick_ok     = (pick_len != 16'd0) && (pick_len <= MAX_LEN);
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // Payload mux; zero whenever no byte is being handed to the sender
  always_comb begin
    udp_data = 8'h00;
    if (udp_tx_enable) udp_data = data_arr[cur_idx];
  end

  // Packet sequencer with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      cur_idx       <= '0;
      cur_ok        <= 1'b0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      grant         <= '0;
      rd_en         <= '0;
      drop          <= '0;
      udp_tx_enable <= 1'b0;
      udp_length    <= '0;
      udp_port_id   <= '0;
      udp_dst_port  <= '0;
      busy          <= 1'b0;
    end else begin
      drop <= '0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            state    <= S_GRANT;
            busy     <= 1'b1;
            cur_idx  <= pick_idx;
            cur_ok   <= pick_ok;
            byte_cnt <= pick_len;
`ifdef UDP_ARB_PRIO0_EN
            if (pick_idx != '0) last_grant <= pick_idx;
`else
            last_grant <= pick_idx;
`endif
            // Grant and header fields only for a legal length; a reject
            // leaves the sender-facing registers untouched.
            if (pick_ok) begin
              grant        <= pick_onehot;
              udp_length   <= pick_len;
              udp_port_id  <= pid_arr[pick_idx];
              udp_dst_port <= dst_arr[pick_idx];
            end else begin
              drop <= pick_onehot;
            end
          end
        end

        S_GRANT: begin
          if (cur_ok) begin
            state         <= S_SEND;
            udp_tx_enable <= 1'b1;
            rd_en         <= grant;
          end else begin
            state   <= S_GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end
        end

        // req is not looked at here: the source owes every latched byte
        S_SEND: begin
          if (byte_cnt == 16'd1) begin
            state         <= S_DRAIN;
            udp_tx_enable <= 1'b0;
            rd_en         <= '0;
          end else begin
            byte_cnt <= byte_cnt - 16'd1;
          end
        end

        S_DRAIN: begin
          if (!udp_active) begin
            state   <= S_GAP;
            grant   <= '0;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: byte-counter sources and a sender that
// stays active 7 cycles past its last tx_enable (DRAIN of 8 cycles).
module tb_udp_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned GAP = 12;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [16*NR-1:0]  req_length = '0;
  logic [8*NR-1:0]   req_port_id = '0;
  logic [16*NR-1:0]  req_dst_port = '0;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     grant, rd_en, drop;
  logic              udp_tx_enable;
  logic [7:0]        udp_data;
  logic [15:0]       udp_length;
  logic [7:0]        udp_port_id;
  logic [15:0]       udp_dst_port;
  logic              udp_active;
  logic              busy;

  udp_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(16'd1444), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_length(req_length),
    .req_port_id(req_port_id), .req_dst_port(req_dst_port), .req_data(req_data),
    .grant(grant), .rd_en(rd_en), .drop(drop), .udp_tx_enable(udp_tx_enable),
    .udp_data(udp_data), .udp_length(udp_length), .udp_port_id(udp_port_id),
    .udp_dst_port(udp_dst_port), .udp_active(udp_active), .busy(busy)
  );

  always #5 clock = ~clock;

  // Sources: each presents a byte counter that advances on rd_en
  logic [7:0] src_byte [NR];
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) src_byte[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NR; i++) if (rd_en[i]) src_byte[i] <= src_byte[i] + 8'h01;
    end
  end
  for (genvar g = 0; g < NR; g++) begin : g_src
    assign req_data[8*g +: 8] = src_byte[g];
  end

  // Sender: busy while bytes arrive and for 7 cycles after the last one
  logic [3:0] hold;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)           hold <= 4'd0;
    else if (udp_tx_enable) hold <= 4'd7;
    else if (hold != 4'd0)  hold <= hold - 4'd1;
  end
  assign udp_active = udp_tx_enable | (hold != 4'd0);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_src(input int i, input logic [15:0] len, input logic [7:0] pid,
                         input logic [15:0] dst);
    req_length[16*i +: 16]   = len;
    req_port_id[8*i +: 8]    = pid;
    req_dst_port[16*i +: 16] = dst;
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int n, g, err, cnt, idx, nd, d0, d1, txc, prev_tx_cyc;
  int order [5];
  int txper [5];
  int rise  [2];
  logic [NR-1:0] prev_grant;
  logic          prev_tx;

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_tx", 32'(udp_tx_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(udp_data), 32'd0);
    check("rst_len", 32'(udp_length), 32'd0);
    check("rst_pid", 32'(udp_port_id), 32'd0);
    check("rst_dst", 32'(udp_dst_port), 32'd0);
    do_reset();

    // ---------------- single request, source 2 ----------------
    set_src(2, 16'd16, 8'd3, 16'd1025);
    req = 4'b0100;
    tick();                                   // GRANT cycle
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_tx_in_grant", 32'(udp_tx_enable), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_len", 32'(udp_length), 32'd16);
    check("t1_pid", 32'(udp_port_id), 32'd3);
    check("t1_dst", 32'(udp_dst_port), 32'd1025);
    req = '0;
    err = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (!udp_tx_enable || udp_data != 8'(k) || rd_en != 4'b0100 || grant != 4'b0100) err++;
    end
    check("t1_stream_errs", 32'(err), 32'd0);
    tick();                                   // first DRAIN cycle
    check("t1_tx_off", 32'(udp_tx_enable), 32'd0);
    check("t1_grant_drain", 32'(grant), 32'h4);
    check("t1_len_hold", 32'(udp_length), 32'd16);
    check("t1_dst_hold", 32'(udp_dst_port), 32'd1025);
    n = 0;
    while (udp_active && n < 50) begin
      tick();
      n++;
    end
    check("t1_drain_wait", 32'(n), 32'd7);
    check("t1_grant_last_drain", 32'(grant), 32'h4);
    tick();                                   // first GAP cycle
    check("t1_grant_gap", 32'(grant), 32'd0);
    g = 0;
    while (busy && g < 100) begin
      g++;
      tick();
    end
    check("t1_gap_len", 32'(g), 32'(GAP));

    // ---------------- all four requesting, length 4 ----------------
    do_reset();
    for (int i = 0; i < NR; i++) set_src(i, 16'd4, 8'(i + 1), 16'(100 + i));
    req = 4'hF;
    n = 0; err = 0; cnt = 0; prev_grant = '0; prev_tx = 1'b0; prev_tx_cyc = 0;
    for (int i = 0; i < 5; i++) begin order[i] = -1; txper[i] = 0; end
    rise[0] = 0; rise[1] = 0;
    while (!(n == 5 && grant == '0) && cnt < 400) begin
      tick();
      cnt++;
      if (grant != '0 && prev_grant == '0 && n < 5) begin
        idx = -1;
        for (int b = 0; b < NR; b++) if (grant[b]) idx = b;
        order[n] = idx;
        n++;
      end
      if (udp_tx_enable) begin
        if (n > 0) txper[n-1]++;
        if (rd_en != grant) err++;
        if (!prev_tx && n >= 1 && n <= 2) rise[n-1] = cnt;
      end else if (rd_en != '0) begin
        err++;
      end
      prev_grant = grant;
      prev_tx    = udp_tx_enable;
    end
    req = '0;
    check("rr_order0", 32'(order[0]), 32'd0);
    check("rr_order1", 32'(order[1]), 32'd1);
    check("rr_order2", 32'(order[2]), 32'd2);
    check("rr_order3", 32'(order[3]), 32'd3);
    check("rr_order4", 32'(order[4]), 32'd0);
    for (int i = 0; i < 5; i++) check("rr_tx_per_pkt", 32'(txper[i]), 32'd4);
    check("rr_rd_en_consistency", 32'(err), 32'd0);
    check("rr_spacing", 32'(rise[1] - rise[0]), 32'd26);
    wait_idle("rr_idle_timeout");

    // ---------------- drops: length 0 then 1445 on source 1 ----------------
    set_src(1, 16'd0, 8'd9, 16'd2000);
    req = 4'b0010;
    nd = 0; txc = 0; d0 = 0; d1 = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (udp_tx_enable) txc++;
      if (drop != '0) begin
        check("drop_vec", 32'(drop), 32'h2);
        check("drop_no_grant", 32'(grant), 32'd0);
        nd++;
        if (nd == 1) begin d0 = c; set_src(1, 16'd1445, 8'd9, 16'd2000); end
        if (nd == 2) begin d1 = c; req = '0; end
      end
    end
    check("drop_count", 32'(nd), 32'd2);
    check("drop_no_tx", 32'(txc), 32'd0);
    check("drop_spacing", 32'(d1 - d0), 32'(GAP + 2));
    check("drop_len_kept", 32'(udp_length), 32'd4);
    check("drop_pid_kept", 32'(udp_port_id), 32'd1);
    check("drop_dst_kept", 32'(udp_dst_port), 32'd100);
    check("drop_idle", 32'(busy), 32'd0);

    // ---------------- reset mid-SEND ----------------
    do_reset();
    set_src(2, 16'd100, 8'd5, 16'd3000);
    req = 4'b0100;
    tick();
    check("mr_grant2", 32'(grant), 32'h4);
    for (int k = 0; k < 5; k++) tick();
    check("mr_byte5", 32'(udp_data), 32'd4);
    reset_n = 1'b0;
    #1;
    check("mr_grant0", 32'(grant), 32'd0);
    check("mr_rd_en0", 32'(rd_en), 32'd0);
    check("mr_drop0", 32'(drop), 32'd0);
    check("mr_tx0", 32'(udp_tx_enable), 32'd0);
    check("mr_busy0", 32'(busy), 32'd0);
    check("mr_data0", 32'(udp_data), 32'd0);
    check("mr_len0", 32'(udp_length), 32'd0);
    check("mr_pid0", 32'(udp_port_id), 32'd0);
    check("mr_dst0", 32'(udp_dst_port), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    set_src(0, 16'd100, 8'd7, 16'd4000);
    req = 4'b0101;
    tick();
    check("mr_regrant", 32'(grant), 32'h1);
    check("mr_len", 32'(udp_length), 32'd100);
    req = '0;
    err = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!udp_tx_enable || udp_data != 8'(k) || rd_en != 4'b0001) err++;
    end
    check("mr_stream_errs", 32'(err), 32'd0);
    tick();
    check("mr_tx_end", 32'(udp_tx_enable), 32'd0);
    wait_idle("mr_idle_timeout");

    // ---------------- req[3] dropped during its SEND ----------------
    do_reset();
    set_src(3, 16'd8, 8'd2, 16'd5555);
    req = 4'b1000;
    tick();
    check("dq_grant", 32'(grant), 32'h8);
    tick();                                   // first SEND cycle
    req = '0;
    cnt = 0; n = 0; err = 0;
    while (busy && cnt < 100) begin
      if (rd_en[3]) n++;
      if (rd_en != '0 && rd_en != 4'b1000) err++;
      cnt++;
      tick();
    end
    check("dq_rd_pulses", 32'(n), 32'd8);
    check("dq_rd_other", 32'(err), 32'd0);
    check("dq_busy_cycles", 32'(cnt), 32'(8 + 8 + GAP));
    check("dq_grant_end", 32'(grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
